// File: rtl/sram_like_bridge_pkg.sv
// Shared encodings for the SRAM-like bridge: channel IDs and arbiter states.
package sram_like_bridge_pkg;

    localparam logic CH_INST = 1'b0;
    localparam logic CH_DATA = 1'b1;

    typedef enum logic [1:0] {
        ARB_IDLE      = 2'd0,
        ARB_HOLD_INST = 2'd1,
        ARB_HOLD_DATA = 2'd2
    } arb_state_t;

    function automatic arb_state_t hold_state(input logic ch);
        return (ch == CH_DATA) ? ARB_HOLD_DATA : ARB_HOLD_INST;
    endfunction

endpackage

// File: rtl/id_fifo.sv
// Small FIFO remembering which channel owns each outstanding transaction.
module id_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 1
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic                     full,
    output logic                     empty,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/sram_like_bridge.sv
// Merges the inst and data SRAM-like channels onto one master port and routes responses back in order.
module sram_like_bridge
    import sram_like_bridge_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int DEPTH     = 4,
    parameter int DATA_PRIO = 1
) (
    input  logic                clk,
    input  logic                resetn,

    input  logic                inst_req,
    input  logic                inst_wr,
    input  logic [1:0]          inst_size,
    input  logic [DATA_W/8-1:0] inst_wstrb,
    input  logic [ADDR_W-1:0]   inst_addr,
    input  logic [DATA_W-1:0]   inst_wdata,
    output logic                inst_addr_ok,
    output logic                inst_data_ok,
    output logic [DATA_W-1:0]   inst_rdata,

    input  logic                data_req,
    input  logic                data_wr,
    input  logic [1:0]          data_size,
    input  logic [DATA_W/8-1:0] data_wstrb,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic                data_addr_ok,
    output logic                data_data_ok,
    output logic [DATA_W-1:0]   data_rdata,

    output logic                m_req,
    output logic                m_wr,
    output logic [1:0]          m_size,
    output logic [DATA_W/8-1:0] m_wstrb,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    input  logic                m_addr_ok,
    input  logic                m_data_ok,
    input  logic [DATA_W-1:0]   m_rdata,

    output logic                err
);

    arb_state_t state;
    logic       rr_data;
    logic       gnt;
    logic       sel_req;
    logic       hs;
    logic       fifo_pop;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_head;
    logic [$clog2(DEPTH):0] fifo_count;

    // A held request keeps its grant so the master port stays stable until accepted.
    always_comb begin
        gnt = CH_INST;
        unique case (state)
            ARB_HOLD_INST: gnt = CH_INST;
            ARB_HOLD_DATA: gnt = CH_DATA;
            default: begin
                if (inst_req && data_req)
                    gnt = (DATA_PRIO != 0) ? CH_DATA : rr_data;
                else if (data_req)
                    gnt = CH_DATA;
                else
                    gnt = CH_INST;
            end
        endcase
    end

    assign sel_req = (gnt == CH_DATA) ? data_req : inst_req;
    assign m_req   = resetn && sel_req && !fifo_full;
    assign hs      = m_req && m_addr_ok;

    assign m_wr    = (gnt == CH_DATA) ? data_wr    : inst_wr;
    assign m_size  = (gnt == CH_DATA) ? data_size  : inst_size;
    assign m_wstrb = (gnt == CH_DATA) ? data_wstrb : inst_wstrb;
    assign m_addr  = (gnt == CH_DATA) ? data_addr  : inst_addr;
    assign m_wdata = (gnt == CH_DATA) ? data_wdata : inst_wdata;

    assign inst_addr_ok = hs && (gnt == CH_INST);
    assign data_addr_ok = hs && (gnt == CH_DATA);

    // Responses return in order; the FIFO head says which channel owns this one.
    assign fifo_pop     = m_data_ok && !fifo_empty;
    assign inst_data_ok = fifo_pop && (fifo_head == CH_INST);
    assign data_data_ok = fifo_pop && (fifo_head == CH_DATA);
    assign inst_rdata   = m_rdata;
    assign data_rdata   = m_rdata;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= ARB_IDLE;
            rr_data <= 1'b0;
            err     <= 1'b0;
        end else begin
            if (m_data_ok && fifo_empty) err <= 1'b1;
            if (hs) rr_data <= (gnt == CH_INST);
            unique case (state)
                ARB_IDLE: begin
                    if (m_req && !m_addr_ok) state <= hold_state(gnt);
                end
                ARB_HOLD_INST, ARB_HOLD_DATA: begin
                    if (hs) state <= ARB_IDLE;
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    id_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (1)
    ) u_id_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (hs),
        .pop    (fifo_pop),
        .din    (gnt),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .head   (fifo_head),
        .count  (fifo_count)
    );

endmodule

// File: tb/tb_sram_like_bridge.sv
// Directed bench for sram_like_bridge: a fixed-priority instance plus a round-robin instance on shared stimulus.
module tb_sram_like_bridge;

    localparam int DW = 32;
    localparam int AW = 32;

    logic clk = 1'b0;
    logic resetn = 1'b1;
    always #5 clk = ~clk;

    logic          inst_req, inst_wr, data_req, data_wr;
    logic [1:0]    inst_size, data_size;
    logic [3:0]    inst_wstrb, data_wstrb;
    logic [AW-1:0] inst_addr, data_addr;
    logic [DW-1:0] inst_wdata, data_wdata;
    logic          m_addr_ok, m_data_ok;
    logic [DW-1:0] m_rdata;

    logic          inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [DW-1:0] inst_rdata, data_rdata;
    logic          m_req, m_wr, err;
    logic [1:0]    m_size;
    logic [3:0]    m_wstrb;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;

    logic          rr_inst_addr_ok, rr_inst_data_ok, rr_data_addr_ok, rr_data_data_ok;
    logic [DW-1:0] rr_inst_rdata, rr_data_rdata;
    logic          rr_m_req, rr_m_wr, rr_err;
    logic [1:0]    rr_m_size;
    logic [3:0]    rr_m_wstrb;
    logic [AW-1:0] rr_m_addr;
    logic [DW-1:0] rr_m_wdata;

    int checks = 0;
    int failures = 0;

    sram_like_bridge #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(4), .DATA_PRIO(1)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_wstrb(m_wstrb), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
        .err(err)
    );

    sram_like_bridge #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(4), .DATA_PRIO(0)) dut_rr (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(rr_inst_addr_ok), .inst_data_ok(rr_inst_data_ok), .inst_rdata(rr_inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(rr_data_addr_ok), .data_data_ok(rr_data_data_ok), .data_rdata(rr_data_rdata),
        .m_req(rr_m_req), .m_wr(rr_m_wr), .m_size(rr_m_size), .m_wstrb(rr_m_wstrb), .m_addr(rr_m_addr),
        .m_wdata(rr_m_wdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
        .err(rr_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_wstrb = 4'h0;
        inst_addr = '0; inst_wdata = '0;
        data_req = 0; data_wr = 0; data_size = 2'd2; data_wstrb = 4'h0;
        data_addr = '0; data_wdata = '0;
        m_addr_ok = 0; m_data_ok = 0; m_rdata = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        resetn = 0;
        repeat (2) @(posedge clk);
        #1 resetn = 1;
    endtask

    task automatic test_reset();
        clear_inputs();
        inst_req = 1; data_req = 1; m_addr_ok = 1; m_data_ok = 1;
        #2 resetn = 0;
        @(negedge clk);
        checks++; if (m_req !== 1'b0) begin failures++; $display("FAIL reset_m_req got=%b want=0", m_req); end
        checks++; if ({inst_addr_ok, data_addr_ok} !== 2'b00) begin failures++; $display("FAIL reset_addr_ok got=%b want=00", {inst_addr_ok, data_addr_ok}); end
        checks++; if ({inst_data_ok, data_data_ok} !== 2'b00) begin failures++; $display("FAIL reset_data_ok got=%b want=00", {inst_data_ok, data_data_ok}); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b want=0", err); end
        do_reset();
    endtask

    task automatic test_single_read();
        do_reset();
        inst_req = 1; inst_addr = 32'hBFC0_0000; m_addr_ok = 1;
        @(negedge clk);
        checks++; if (m_addr !== 32'hBFC0_0000) begin failures++; $display("FAIL single_m_addr got=%h want=bfc00000", m_addr); end
        checks++; if ({m_req, inst_addr_ok, data_addr_ok} !== 3'b110) begin failures++; $display("FAIL single_addr_ok got=%b want=110", {m_req, inst_addr_ok, data_addr_ok}); end
        tick();
        inst_req = 0; m_addr_ok = 0;
        @(negedge clk);
        checks++; if (m_req !== 1'b0) begin failures++; $display("FAIL single_idle_m_req got=%b want=0", m_req); end
        tick();
        m_data_ok = 1; m_rdata = 32'h3C01_0001;
        @(negedge clk);
        checks++; if ({inst_data_ok, data_data_ok} !== 2'b10) begin failures++; $display("FAIL single_data_ok got=%b want=10", {inst_data_ok, data_data_ok}); end
        checks++; if (inst_rdata !== 32'h3C01_0001) begin failures++; $display("FAIL single_rdata got=%h want=3c010001", inst_rdata); end
        tick();
        m_data_ok = 0;
        @(negedge clk);
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL single_err got=%b want=0", err); end
    endtask

    task automatic test_contention();
        do_reset();
        inst_req = 1; inst_addr = 32'h0000_1000;
        data_req = 1; data_addr = 32'h8000_0040; data_wr = 1; data_wdata = 32'hDEAD_BEEF;
        data_wstrb = 4'hF; m_addr_ok = 1;
        @(negedge clk);
        checks++; if (m_addr !== 32'h8000_0040) begin failures++; $display("FAIL contend_first_addr got=%h want=80000040", m_addr); end
        checks++; if ({inst_addr_ok, data_addr_ok} !== 2'b01) begin failures++; $display("FAIL contend_first_ok got=%b want=01", {inst_addr_ok, data_addr_ok}); end
        checks++; if ({m_wr, m_wstrb, m_wdata} !== {1'b1, 4'hF, 32'hDEAD_BEEF}) begin failures++; $display("FAIL contend_wdata got=%b/%h/%h want=1/f/deadbeef", m_wr, m_wstrb, m_wdata); end
        tick();
        data_req = 0;
        @(negedge clk);
        checks++; if (m_addr !== 32'h0000_1000) begin failures++; $display("FAIL contend_second_addr got=%h want=00001000", m_addr); end
        checks++; if ({inst_addr_ok, data_addr_ok, m_wr} !== 3'b100) begin failures++; $display("FAIL contend_second_ok got=%b want=100", {inst_addr_ok, data_addr_ok, m_wr}); end
        tick();
        inst_req = 0; m_addr_ok = 0; m_data_ok = 1; m_rdata = 32'h1111_2222;
        @(negedge clk);
        checks++; if ({inst_data_ok, data_data_ok} !== 2'b01) begin failures++; $display("FAIL contend_resp1 got=%b want=01", {inst_data_ok, data_data_ok}); end
        checks++; if (data_rdata !== 32'h1111_2222) begin failures++; $display("FAIL contend_resp1_rdata got=%h want=11112222", data_rdata); end
        tick();
        m_rdata = 32'h3333_4444;
        @(negedge clk);
        checks++; if ({inst_data_ok, data_data_ok} !== 2'b10) begin failures++; $display("FAIL contend_resp2 got=%b want=10", {inst_data_ok, data_data_ok}); end
        tick();
        m_data_ok = 0;
        @(negedge clk);
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL contend_err got=%b want=0", err); end
    endtask

    task automatic test_hold();
        do_reset();
        inst_req = 1; inst_addr = 32'h0000_2000; m_addr_ok = 0;
        @(negedge clk);
        checks++; if ({m_req, inst_addr_ok} !== 2'b10) begin failures++; $display("FAIL hold_c0 got=%b want=10", {m_req, inst_addr_ok}); end
        tick();
        data_req = 1; data_addr = 32'h8000_2000;
        for (int c = 1; c < 3; c++) begin
            @(negedge clk);
            checks++; if (m_addr !== 32'h0000_2000) begin failures++; $display("FAIL hold_addr_c%0d got=%h want=00002000", c, m_addr); end
            checks++; if ({inst_addr_ok, data_addr_ok} !== 2'b00) begin failures++; $display("FAIL hold_ok_c%0d got=%b want=00", c, {inst_addr_ok, data_addr_ok}); end
            tick();
        end
        m_addr_ok = 1;
        @(negedge clk);
        checks++; if ({m_addr, inst_addr_ok, data_addr_ok} !== {32'h0000_2000, 2'b10}) begin failures++; $display("FAIL hold_accept got=%h/%b want=00002000/10", m_addr, {inst_addr_ok, data_addr_ok}); end
        tick();
        inst_req = 0;
        @(negedge clk);
        checks++; if ({m_addr, inst_addr_ok, data_addr_ok} !== {32'h8000_2000, 2'b01}) begin failures++; $display("FAIL hold_idle_data got=%h/%b want=80002000/01", m_addr, {inst_addr_ok, data_addr_ok}); end
        tick();
        data_req = 0; m_addr_ok = 0; m_data_ok = 1;
        @(negedge clk);
        checks++; if ({inst_data_ok, data_data_ok} !== 2'b10) begin failures++; $display("FAIL hold_resp1 got=%b want=10", {inst_data_ok, data_data_ok}); end
        tick();
        @(negedge clk);
        checks++; if ({inst_data_ok, data_data_ok} !== 2'b01) begin failures++; $display("FAIL hold_resp2 got=%b want=01", {inst_data_ok, data_data_ok}); end
        tick();
        m_data_ok = 0;
    endtask

    task automatic test_full();
        do_reset();
        inst_req = 1; inst_addr = 32'h0000_3000; m_addr_ok = 1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++; if (inst_addr_ok !== 1'b1) begin failures++; $display("FAIL full_fill_c%0d got=%b want=1", c, inst_addr_ok); end
            tick();
        end
        @(negedge clk);
        checks++; if ({m_req, inst_addr_ok} !== 2'b00) begin failures++; $display("FAIL full_block got=%b want=00", {m_req, inst_addr_ok}); end
        tick();
        m_data_ok = 1; m_rdata = 32'h0000_00AA;
        @(negedge clk);
        checks++; if ({m_req, inst_addr_ok, inst_data_ok} !== 3'b001) begin failures++; $display("FAIL full_no_bypass got=%b want=001", {m_req, inst_addr_ok, inst_data_ok}); end
        tick();
        m_data_ok = 0;
        @(negedge clk);
        checks++; if ({m_req, inst_addr_ok} !== 2'b11) begin failures++; $display("FAIL full_reopen got=%b want=11", {m_req, inst_addr_ok}); end
        tick();
        @(negedge clk);
        checks++; if (m_req !== 1'b0) begin failures++; $display("FAIL full_refill got=%b want=0", m_req); end
        clear_inputs();
    endtask

    task automatic test_error_reset();
        do_reset();
        m_data_ok = 1;
        @(negedge clk);
        checks++; if ({inst_data_ok, data_data_ok} !== 2'b00) begin failures++; $display("FAIL err_empty_data_ok got=%b want=00", {inst_data_ok, data_data_ok}); end
        tick();
        m_data_ok = 0;
        @(negedge clk);
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_set got=%b want=1", err); end
        tick();
        @(negedge clk);
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b want=1", err); end
        inst_req = 1; inst_addr = 32'h0000_4000; m_addr_ok = 1;
        tick();
        @(negedge clk);
        checks++; if (inst_addr_ok !== 1'b1) begin failures++; $display("FAIL err_hs1 got=%b want=1", inst_addr_ok); end
        tick();
        @(negedge clk);
        checks++; if (inst_addr_ok !== 1'b1) begin failures++; $display("FAIL err_hs2 got=%b want=1", inst_addr_ok); end
        tick();
        resetn = 0;
        #1;
        checks++; if ({err, m_req, inst_addr_ok} !== 3'b000) begin failures++; $display("FAIL err_in_reset got=%b want=000", {err, m_req, inst_addr_ok}); end
        do_reset();
        @(negedge clk);
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_after_reset got=%b want=0", err); end
        for (int p = 0; p < 2; p++) begin
            m_data_ok = 1;
            @(negedge clk);
            checks++; if ({inst_data_ok, data_data_ok} !== 2'b00) begin failures++; $display("FAIL err_stale_resp%0d got=%b want=00", p, {inst_data_ok, data_data_ok}); end
            tick();
            m_data_ok = 0;
            tick();
        end
        @(negedge clk);
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_stale_set got=%b want=1", err); end
    endtask

    task automatic test_round_robin();
        do_reset();
        inst_req = 1; inst_addr = 32'h0000_5000;
        data_req = 1; data_addr = 32'h8000_5000; m_addr_ok = 1;
        @(negedge clk);
        checks++; if ({rr_m_addr, rr_inst_addr_ok, rr_data_addr_ok} !== {32'h0000_5000, 2'b10}) begin failures++; $display("FAIL rr_first got=%h/%b want=00005000/10", rr_m_addr, {rr_inst_addr_ok, rr_data_addr_ok}); end
        tick();
        @(negedge clk);
        checks++; if ({rr_m_addr, rr_inst_addr_ok, rr_data_addr_ok} !== {32'h8000_5000, 2'b01}) begin failures++; $display("FAIL rr_second got=%h/%b want=80005000/01", rr_m_addr, {rr_inst_addr_ok, rr_data_addr_ok}); end
        tick();
        @(negedge clk);
        checks++; if ({rr_inst_addr_ok, rr_data_addr_ok} !== 2'b10) begin failures++; $display("FAIL rr_third got=%b want=10", {rr_inst_addr_ok, rr_data_addr_ok}); end
        tick();
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_hold();
        test_full();
        test_error_reset();
        test_round_robin();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
